acia_fifo: RTL and testbench

- Parametrised successor to the 6850-style ACIA: same control/status/data semantics, plus a runtime-programmable baud divisor and TX/RX FIFOs of configurable depth.
- Includes its own TX serializer and RX deserializer.
- Sits on the 6502 bus, chip-selected by the address decoder, with an IRQ to the CPU.

---
 rtl/acia_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_acia_fifo.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_fifo.sv
// 6850-style ACIA with runtime baud divisor, TX/RX FIFOs and its own serializer/deserializer.
// Optional: define ACIA_FIFO_LOOPBACK_EN to make control bit 2 an internal TX->RX loopback.
module acia_fifo #(
    parameter int CLK_FREQ     = 25000000,
    parameter int BAUD_DEFAULT = 9600,
    parameter int TX_AW        = 4,
    parameter int RX_AW        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);

    localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / BAUD_DEFAULT - 1);
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam int RX_DEPTH = 1 << RX_AW;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]  ctrl;
    logic [15:0] divisor;
    logic        oe;
    logic        fe;
    logic        bus_wr;
    logic        bus_rd;
    logic        stat_rd;
    logic        mr;
    logic        rx_ie;
    logic [1:0]  tx_ctrl;
    logic        tdre;
    logic        rdrf;
    logic [7:0]  status;

    assign bus_wr  = cs & we;
    assign bus_rd  = cs & ~we;
    assign stat_rd = bus_rd & (addr == 2'd0);
    assign mr      = (ctrl[1:0] == 2'b11);
    assign rx_ie   = ctrl[7];
    assign tx_ctrl = ctrl[6:5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            divisor <= DIV_RESET;
        end else if (bus_wr) begin
            case (addr)
                2'd0:    ctrl <= din;
                2'd2:    divisor[7:0] <= din;
                2'd3:    divisor[15:8] <= din;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------ TX FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wp;
    logic [TX_AW-1:0] tx_rp;
    logic [TX_AW:0]   tx_cnt;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;
    tx_state_t        tx_state;
    logic [15:0]      tx_tmr;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_sh;
    logic             tx_ser;

    // Count never exceeds depth, so its MSB alone marks full.
    assign tx_full  = tx_cnt[TX_AW];
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = bus_wr & (addr == 2'd1) & ~tx_full & ~mr;
    assign tx_pop   = (tx_state == TX_IDLE) & ~tx_empty & ~mr;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else if (mr) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + TX_AW'(1);
            if (tx_pop)
                tx_rp <= tx_rp + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TX_AW + 1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TX_AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------ TX serializer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_tmr   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_ser   <= 1'b1;
        end else if (mr) begin
            tx_state <= TX_IDLE;
            tx_tmr   <= '0;
            tx_idx   <= '0;
            tx_ser   <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_ser <= 1'b1;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_sh    <= tx_mem[tx_rp];
                        tx_tmr   <= divisor;
                        tx_ser   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tmr == '0) begin
                        tx_state <= TX_DATA;
                        tx_tmr   <= divisor;
                        tx_idx   <= '0;
                        tx_ser   <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                    end else begin
                        tx_tmr <= tx_tmr - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tmr == '0) begin
                        tx_tmr <= divisor;
                        if (tx_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx_ser   <= 1'b1;
                        end else begin
                            tx_idx <= tx_idx + 3'd1;
                            tx_ser <= tx_sh[0];
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                        end
                    end else begin
                        tx_tmr <= tx_tmr - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tmr == '0)
                        tx_state <= TX_IDLE;
                    else
                        tx_tmr <= tx_tmr - 16'd1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX input select
    logic rx_s1;
    logic rx_s2;
    logic rx_in;
    logic rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_in;
        end
    end

`ifdef ACIA_FIFO_LOOPBACK_EN
    logic ctrl_unused;
    assign ctrl_unused = ^ctrl[4:3];
    assign rx_in = ctrl[2] ? tx_ser : rx_s2;
    assign tx    = ctrl[2] ? 1'b1 : tx_ser;
`else
    logic ctrl_unused;
    assign ctrl_unused = ^ctrl[4:2];
    assign rx_in = rx_s2;
    assign tx    = tx_ser;
`endif

    // ------------------------------------------------------------------ RX deserializer
    rx_state_t   rx_state;
    logic [15:0] rx_tmr;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_sh;
    logic [16:0] div_p1;
    logic [15:0] rx_half_m1;
    logic        rx_sample;
    logic        rx_stop_ok;
    logic        rx_stop_bad;

    assign div_p1      = {1'b0, divisor} + 17'd1;
    assign rx_half_m1  = div_p1[16:1] - 16'd1;
    assign rx_sample   = (rx_state != RX_IDLE) && (rx_tmr == '0);
    assign rx_stop_ok  = rx_sample && (rx_state == RX_STOP) && rx_in && !mr;
    assign rx_stop_bad = rx_sample && (rx_state == RX_STOP) && !rx_in && !mr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_tmr   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
        end else if (mr) begin
            rx_state <= RX_IDLE;
            rx_tmr   <= '0;
            rx_idx   <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_in) begin
                        rx_state <= RX_START;
                        rx_tmr   <= rx_half_m1;
                    end
                end
                RX_START: begin
                    if (rx_tmr == '0) begin
                        if (rx_in) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_tmr   <= divisor;
                            rx_idx   <= '0;
                        end
                    end else begin
                        rx_tmr <= rx_tmr - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tmr == '0) begin
                        rx_sh  <= {rx_in, rx_sh[7:1]};
                        rx_tmr <= divisor;
                        if (rx_idx == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_idx <= rx_idx + 3'd1;
                    end else begin
                        rx_tmr <= rx_tmr - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tmr == '0)
                        rx_state <= RX_IDLE;
                    else
                        rx_tmr <= rx_tmr - 16'd1;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wp;
    logic [RX_AW-1:0] rx_rp;
    logic [RX_AW:0]   rx_cnt;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic             set_oe;

    assign rx_full  = rx_cnt[RX_AW];
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = bus_rd & (addr == 2'd1) & ~rx_empty & ~mr;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign rx_push  = rx_stop_ok & (~rx_full | rx_pop);
    assign set_oe   = rx_stop_ok & rx_full & ~rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else if (mr) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + RX_AW'(1);
            if (rx_pop)
                rx_rp <= rx_rp + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RX_AW + 1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RX_AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------ flags, status, read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe <= 1'b0;
            fe <= 1'b0;
        end else if (mr) begin
            oe <= 1'b0;
            fe <= 1'b0;
        end else begin
            oe <= set_oe | (oe & ~stat_rd);
            fe <= rx_stop_bad | (fe & ~stat_rd);
        end
    end

    assign tdre   = ~tx_full;
    assign rdrf   = ~rx_empty;
    assign irq    = (rx_ie & (rdrf | oe | fe)) | ((tx_ctrl == 2'b01) & tdre);
    assign status = {irq, 1'b0, oe, fe, 2'b00, tdre, rdrf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (bus_rd) begin
            case (addr)
                2'd0: dout <= status;
                2'd1: dout <= rx_mem[rx_rp];
                2'd2: dout <= divisor[7:0];
                2'd3: dout <= divisor[15:8];
            endcase
        end
    end

endmodule

// File: tb/tb_acia_fifo.sv
// Self-checking bench for acia_fifo: randomized data against a queue-based behavioural model.
module tb_acia_fifo;

    localparam int CLK_FREQ = 25000000;
    localparam int BAUD     = 9600;
    localparam int DEPTH    = 16;
    localparam int DIV_EXP  = CLK_FREQ / BAUD - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       rx = 1'b1;
    logic       tx;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    logic       m_oe = 1'b0;
    logic       m_fe = 1'b0;
    logic [7:0] m_ctrl = 8'h00;

    acia_fifo #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_DEFAULT(BAUD),
        .TX_AW       (4),
        .RX_AW       (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cs   (cs),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .rx   (rx),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
        if (a == 2'd0) m_ctrl = d;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0;
        d = dout;
    endtask

    // Drives one frame at 4 clocks per bit (divisor 3), then idles long enough for the stop sample.
    task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (4) @(negedge clk);
        end
        rx = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic void model_rx(input logic [7:0] d, input logic stop_bit);
        if (!stop_bit) m_fe = 1'b1;
        else if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else m_oe = 1'b1;
    endfunction

    function automatic logic [7:0] exp_status(input logic tdre_v);
        logic rdrf_v;
        logic irq_v;
        rdrf_v = (rx_q.size() != 0);
        irq_v  = (m_ctrl[7] & (rdrf_v | m_oe | m_fe)) | ((m_ctrl[6:5] == 2'b01) & tdre_v);
        return {irq_v, 1'b0, m_oe, m_fe, 2'b00, tdre_v, rdrf_v};
    endfunction

    // Decodes one frame from the tx pin at 4 clocks per bit; ok drops on timeout or bad framing.
    task automatic capture_frame(output logic [7:0] b, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b1;
        b = 8'h00;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = tx;
        end
        repeat (4) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        n_checks++;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h required 00", dout); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq); end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h required 02", v); end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 8'(DIV_EXP)) begin n_fail++; $display("FAIL reset_div_lo: got %h required %h", v, 8'(DIV_EXP)); end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 8'(DIV_EXP >> 8)) begin n_fail++; $display("FAIL reset_div_hi: got %h required %h", v, 8'(DIV_EXP >> 8)); end
        bus_write(2'd1, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_tx_low: got %b required 0", tx); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b required 1", tx); end
        n_checks++;
        if (dout !== 8'h00) begin n_fail++; $display("FAIL async_reset_dout: got %h required 00", dout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ctrl = 8'h00;
        bus_read(2'd0, v);
        n_checks++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL post_reset_status: got %h required 02", v); end
    endtask

    task automatic test_divisor();
        logic [7:0] v;
        bus_write(2'd2, 8'h03);
        bus_write(2'd3, 8'h00);
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 8'h03) begin n_fail++; $display("FAIL div_lo_rb: got %h required 03", v); end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL div_hi_rb: got %h required 00", v); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] f;
        logic exp;
        f = {1'b1, 8'h55, 1'b0};
        bus_write(2'd1, 8'h55);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_before_start: got %b required 1", tx); end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                #1;
                exp = f[b];
                n_checks++;
                if (tx !== exp) begin
                    n_fail++;
                    $display("FAIL tx_frame_bit%0d_clk%0d: got %b required %b", b, c, tx, exp);
                end
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_after_frame: got %b required 1", tx); end
    endtask

    // The serializer pops the first byte one clock after it lands, so 16 more fit and the 18th is dropped.
    task automatic test_tx_full();
        logic [7:0] sent [18];
        logic [7:0] got [$];
        logic [7:0] st;
        bit idle_ok;
        for (int i = 0; i < 18; i++) sent[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 18; i++) bus_write(2'd1, sent[i]);
                bus_read(2'd0, st);
                n_checks++;
                if (st !== exp_status(1'b0)) begin
                    n_fail++;
                    $display("FAIL tx_full_status: got %h required %h", st, exp_status(1'b0));
                end
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    logic [7:0] b;
                    bit ok;
                    capture_frame(b, ok);
                    n_checks++;
                    if (!ok) begin n_fail++; $display("FAIL tx_capture_%0d: got bad/absent frame required valid frame", k); end
                    got.push_back(b);
                end
            end
        join
        for (int k = 0; k < 17; k++) begin
            n_checks++;
            if (got[k] !== sent[k]) begin
                n_fail++;
                $display("FAIL tx_full_byte%0d: got %h required %h", k, got[k], sent[k]);
            end
        end
        idle_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        n_checks++;
        if (!idle_ok) begin n_fail++; $display("FAIL tx_dropped_byte: got extra frame required idle line"); end
        bus_read(2'd0, st);
        n_checks++;
        if (st !== exp_status(1'b1)) begin n_fail++; $display("FAIL tx_drained_status: got %h required %h", st, exp_status(1'b1)); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] v;
        logic [7:0] d;
        logic [7:0] e;
        send_rx_frame(8'hA5, 1'b1);
        model_rx(8'hA5, 1'b1);
        bus_read(2'd0, v);
        e = exp_status(1'b1); m_oe = 1'b0; m_fe = 1'b0;
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL rx_rdrf_status: got %h required %h", v, e); end
        bus_read(2'd1, v);
        e = rx_q.pop_front();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL rx_a5_data: got %h required %h", v, e); end
        bus_read(2'd0, v);
        e = exp_status(1'b1);
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL rx_empty_status: got %h required %h", v, e); end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_rx_frame(d, 1'b1);
            model_rx(d, 1'b1);
            bus_read(2'd1, v);
            e = rx_q.pop_front();
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL rx_rand_data%0d: got %h required %h", i, v, e); end
        end
    endtask

    task automatic test_rx_glitch();
        logic [7:0] v;
        logic [7:0] e;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(2'd0, v);
        e = exp_status(1'b1);
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL rx_glitch_status: got %h required %h", v, e); end
    endtask

    task automatic test_overrun_framing();
        logic [7:0] v;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            send_rx_frame(d, 1'b1);
            model_rx(d, 1'b1);
        end
        d = 8'($urandom);
        send_rx_frame(d, 1'b0);
        model_rx(d, 1'b0);
        bus_read(2'd0, v);
        e = exp_status(1'b1); m_oe = 1'b0; m_fe = 1'b0;
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL oe_fe_status: got %h required %h", v, e); end
        bus_read(2'd0, v);
        e = exp_status(1'b1);
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL flags_cleared_status: got %h required %h", v, e); end
        for (int i = 0; i < DEPTH; i++) begin
            bus_read(2'd1, v);
            e = rx_q.pop_front();
            n_checks++;
            if (v !== e) begin n_fail++; $display("FAIL overrun_data%0d: got %h required %h", i, v, e); end
        end
        bus_read(2'd0, v);
        e = exp_status(1'b1);
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL overrun_drained_status: got %h required %h", v, e); end
    endtask

    task automatic test_irq();
        logic [7:0] v;
        logic [7:0] d;
        logic [7:0] e;
        bus_write(2'd0, 8'h80);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rxie_empty: got %b required 0", irq); end
        d = 8'($urandom);
        send_rx_frame(d, 1'b1);
        model_rx(d, 1'b1);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx_byte: got %b required 1", irq); end
        bus_read(2'd1, v);
        e = rx_q.pop_front();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL irq_rx_data: got %h required %h", v, e); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_read: got %b required 0", irq); end
        bus_write(2'd0, 8'h20);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_tdre: got %b required 1", irq); end
        bus_write(2'd0, 8'h00);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b required 0", irq); end
    endtask

    task automatic test_master_reset();
        logic [7:0] v;
        logic [7:0] d;
        bit idle_ok;
        d = 8'($urandom);
        send_rx_frame(d, 1'b0);
        model_rx(d, 1'b0);
        d = 8'($urandom);
        send_rx_frame(d, 1'b1);
        model_rx(d, 1'b1);
        for (int i = 0; i < 3; i++) bus_write(2'd1, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL mr_pre_tx_low: got %b required 0", tx); end
        bus_write(2'd0, 8'h03);
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL mr_tx_high: got %b required 1", tx); end
        rx_q.delete();
        m_oe = 1'b0;
        m_fe = 1'b0;
        bus_read(2'd0, v);
        n_checks++;
        if (v !== exp_status(1'b1)) begin n_fail++; $display("FAIL mr_status: got %h required %h", v, exp_status(1'b1)); end
        bus_read(2'd2, v);
        n_checks++;
        if (v !== 8'h03) begin n_fail++; $display("FAIL mr_div_lo: got %h required 03", v); end
        bus_read(2'd3, v);
        n_checks++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL mr_div_hi: got %h required 00", v); end
        bus_write(2'd0, 8'h00);
        idle_ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) idle_ok = 1'b0;
        end
        n_checks++;
        if (!idle_ok) begin n_fail++; $display("FAIL mr_flushed_tx: got frame after flush required idle line"); end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== exp_status(1'b1)) begin n_fail++; $display("FAIL mr_release_status: got %h required %h", v, exp_status(1'b1)); end
    endtask

`ifdef ACIA_FIFO_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] v;
        logic [7:0] e;
        bit pin_ok;
        bus_write(2'd0, 8'h04);
        rx = 1'b0;
        bus_write(2'd1, 8'h3C);
        rx_q.push_back(8'h3C);
        pin_ok = 1'b1;
        repeat (55) begin
            @(negedge clk);
            if (tx !== 1'b1) pin_ok = 1'b0;
        end
        n_checks++;
        if (!pin_ok) begin n_fail++; $display("FAIL loop_tx_pin: got low pulse required constant 1"); end
        rx = 1'b1;
        bus_read(2'd1, v);
        e = rx_q.pop_front();
        n_checks++;
        if (v !== e) begin n_fail++; $display("FAIL loop_data: got %h required %h", v, e); end
        bus_read(2'd0, v);
        n_checks++;
        if (v !== exp_status(1'b1)) begin n_fail++; $display("FAIL loop_status: got %h required %h", v, exp_status(1'b1)); end
        repeat (4) @(negedge clk);
        bus_write(2'd0, 8'h00);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_divisor();
        test_tx_frame();
        test_tx_full();
        test_rx_basic();
        test_rx_glitch();
        test_overrun_framing();
        test_irq();
        test_master_reset();
`ifdef ACIA_FIFO_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
